// File: rtl/ram_stream_fifo_pkg.sv
// ============================================================================
// Module : ram_stream_fifo_pkg
// Brief  : Shared sizing helpers and defaults for the RAM-backed stream FIFO.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_stream_fifo_pkg;

    localparam int DEPTH_DEFAULT = 16;
    localparam int WIDTH_DEFAULT = 32;
    localparam int BUF_ENTRIES   = 2;

    // Pointer carries one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + BUF_ENTRIES) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_stream_fifo_ram.sv
// ============================================================================
// Module : Ram_1w_1rs
// Brief  : One write port, one synchronous read port RAM with registered rd_data.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module Ram_1w_1rs #(
    parameter int    wordCount      = 16,
    parameter int    wordWidth      = 32,
    parameter bit    clockCrossing  = 1'b0,
    parameter string technology     = "auto",
    parameter string readUnderWrite = "dontCare",
    parameter int    wrMaskWidth    = 1,
    parameter bit    wrMaskEnable   = 1'b0
) (
    input  logic                         wr_clk,
    input  logic                         wr_en,
    input  logic [wrMaskWidth-1:0]       wr_mask,
    input  logic [$clog2(wordCount)-1:0] wr_addr,
    input  logic [wordWidth-1:0]         wr_data,
    input  logic                         rd_clk,
    input  logic                         rd_en,
    input  logic [$clog2(wordCount)-1:0] rd_addr,
    output logic [wordWidth-1:0]         rd_data
);

    logic [wordWidth-1:0] r_mem [wordCount];

    // Mapping hints only; the behavioural model is identical for every choice.
    logic w_unused_cfg;
    assign w_unused_cfg = clockCrossing ^ (technology == "auto") ^ (readUnderWrite == "dontCare");

    always_ff @(posedge wr_clk) begin
        if (wr_en && (!wrMaskEnable || (|wr_mask))) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (rd_en) begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_stream_fifo.sv
// ============================================================================
// Module : ram_stream_fifo
// Brief  : Valid/ready FIFO in block RAM with a 2-entry buffer hiding read latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_stream_fifo
    import ram_stream_fifo_pkg::*;
#(
    parameter int    DEPTH      = DEPTH_DEFAULT,
    parameter int    WIDTH      = WIDTH_DEFAULT,
    parameter string TECHNOLOGY = "auto"
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [WIDTH-1:0]             push_payload,
    output logic                         pop_valid,
    input  logic                         pop_ready,
    output logic [WIDTH-1:0]             pop_payload,
    output logic [occ_width(DEPTH)-1:0]  occupancy
);

    localparam int PTR_W  = ptr_width(DEPTH);
    localparam int OCC_W  = occ_width(DEPTH);
    localparam int ADDR_W = PTR_W - 1;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] payload;
    } buf_entry_t;

    logic [PTR_W-1:0] r_push_ptr;
    logic [PTR_W-1:0] r_pop_ptr;
    logic [PTR_W-1:0] w_ram_count;
    logic             r_inflight;
    buf_entry_t       r_head;
    buf_entry_t       r_tail;
    buf_entry_t       w_head_nxt;
    buf_entry_t       w_tail_nxt;
    logic [1:0]       w_buf_count;
    logic             w_push_fire;
    logic             w_pop_fire;
    logic             w_rd_en;
    logic [WIDTH-1:0] w_rd_data;

    assign w_ram_count = r_push_ptr - r_pop_ptr;
    assign push_ready  = (w_ram_count != PTR_W'(DEPTH));
    assign w_push_fire = push_valid && push_ready;

    assign w_buf_count = {1'b0, r_head.valid} + {1'b0, r_tail.valid};
    assign pop_valid   = (w_buf_count != 2'd0);
    assign pop_payload = r_head.payload;
    assign w_pop_fire  = pop_valid && pop_ready;

    // Only issue when the landing word is guaranteed a free buffer slot.
    assign w_rd_en = (w_ram_count != '0) &&
                     (({1'b0, w_buf_count} + {2'b00, r_inflight} - {2'b00, w_pop_fire})
                      < 3'(BUF_ENTRIES));

    assign occupancy = OCC_W'(w_ram_count) + OCC_W'(r_inflight) + OCC_W'(w_buf_count);

    always_comb begin
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        if (w_pop_fire) begin
            w_head_nxt       = r_tail;
            w_tail_nxt.valid = 1'b0;
        end
        if (r_inflight) begin
            if (!w_head_nxt.valid) begin
                w_head_nxt = {1'b1, w_rd_data};
            end else begin
                w_tail_nxt = {1'b1, w_rd_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_push_ptr <= '0;
            r_pop_ptr  <= '0;
            r_inflight <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
        end else begin
            if (w_push_fire) begin
                r_push_ptr <= r_push_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_pop_ptr <= r_pop_ptr + 1'b1;
            end
            r_inflight <= w_rd_en;
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
        end
    end

    Ram_1w_1rs #(
        .wordCount      (DEPTH),
        .wordWidth      (WIDTH),
        .clockCrossing  (1'b0),
        .technology     (TECHNOLOGY),
        .readUnderWrite ("dontCare"),
        .wrMaskWidth    (1),
        .wrMaskEnable   (1'b0)
    ) u_ram (
        .wr_clk  (clk),
        .wr_en   (w_push_fire),
        .wr_mask (1'b1),
        .wr_addr (r_push_ptr[ADDR_W-1:0]),
        .wr_data (push_payload),
        .rd_clk  (clk),
        .rd_en   (w_rd_en),
        .rd_addr (r_pop_ptr[ADDR_W-1:0]),
        .rd_data (w_rd_data)
    );

endmodule

`default_nettype wire
